// File: rtl/rmii_frame_tx_if.sv
// rtl/rmii_frame_tx_if.sv - send/upstream-dibit/RMII signal bundle for rmii_frame_tx
interface rmii_frame_tx_if;
    logic        send;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        stall;
    logic        txen;
    logic [1:0]  txd;
    logic        busy;
    logic        underrun_err;
    logic [15:0] frame_count;

    modport master (output send, axiiv, axiid,
                    input  stall, txen, txd, busy, underrun_err, frame_count);
    modport slave  (input  send, axiiv, axiid,
                    output stall, txen, txd, busy, underrun_err, frame_count);
endinterface

// File: rtl/rmii_frame_tx.sv
// rtl/rmii_frame_tx.sv - wraps paced payload dibits into an RMII frame with preamble, FCS and IFG
module rmii_frame_tx #(
    parameter int PAYLOAD_DIBITS = 5600,
    parameter int LEAD           = 3,
    parameter int IFG_DIBITS     = 48
) (
    input  logic           clk,
    input  logic           rst_n,
    rmii_frame_tx_if.slave bus
);
    localparam logic [2:0]  ST_IDLE  = 3'd0;
    localparam logic [2:0]  ST_PRE   = 3'd1;
    localparam logic [2:0]  ST_PAY   = 3'd2;
    localparam logic [2:0]  ST_FCS   = 3'd3;
    localparam logic [2:0]  ST_IFG   = 3'd4;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    // Preamble count at which the first request is registered; negative means the send edge itself.
    localparam int          REQ_START = 30 - LEAD;
    localparam logic [15:0] PAY_LAST  = 16'(PAYLOAD_DIBITS - 1);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_DIBITS - 1);

    logic [2:0]  state_q,   state_d;
    logic [4:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [3:0]  fcs_cnt_q, fcs_cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [15:0] req_cnt_q, req_cnt_d;
    logic [31:0] crc_q,     crc_d;
    logic        stall_q,   stall_d;
    logic        txen_q,    txen_d;
    logic [1:0]  txd_q,     txd_d;
    logic        busy_q,    busy_d;
    logic        err_q,     err_d;
    logic [15:0] fc_q,      fc_d;
    logic        start_req;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    assign start_req = (REQ_START < 0) ? (state_q == ST_IDLE && bus.send)
                                       : (state_q == ST_PRE && int'(pre_cnt_q) == REQ_START);

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        pay_cnt_d = pay_cnt_q;
        fcs_cnt_d = fcs_cnt_q;
        ifg_cnt_d = ifg_cnt_q;
        req_cnt_d = req_cnt_q;
        crc_d     = crc_q;
        stall_d   = stall_q;
        txen_d    = txen_q;
        txd_d     = txd_q;
        err_d     = err_q;
        fc_d      = fc_q;

        // Request window: one stall-low cycle per payload dibit, independent of the tx state.
        if (!stall_q) begin
            if (req_cnt_q == PAY_LAST) begin
                stall_d = 1'b1;
            end else begin
                req_cnt_d = req_cnt_q + 16'd1;
            end
        end
        if (start_req) begin
            stall_d   = 1'b0;
            req_cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                txen_d = 1'b0;
                txd_d  = 2'b00;
                if (bus.send) begin
                    state_d   = ST_PRE;
                    pre_cnt_d = '0;
                    txen_d    = 1'b1;
                    txd_d     = 2'b01;
                    err_d     = 1'b0;
                end
            end
            ST_PRE: begin
                if (pre_cnt_q == 5'd30) begin
                    txd_d     = 2'b11;
                    state_d   = ST_PAY;
                    pay_cnt_d = '0;
                    crc_d     = 32'hFFFFFFFF;
                end else begin
                    txd_d     = 2'b01;
                    pre_cnt_d = pre_cnt_q + 5'd1;
                end
            end
            ST_PAY: begin
                if (!bus.axiiv) begin
                    txen_d    = 1'b0;
                    txd_d     = 2'b00;
                    stall_d   = 1'b1;
                    err_d     = 1'b1;
                    state_d   = ST_IFG;
                    ifg_cnt_d = '0;
                end else begin
                    txd_d = bus.axiid;
                    crc_d = crc_dibit(crc_q, bus.axiid);
                    if (pay_cnt_q == PAY_LAST) begin
                        state_d   = ST_FCS;
                        fcs_cnt_d = '0;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 16'd1;
                    end
                end
            end
            ST_FCS: begin
                // Shift the register out LSB dibit first; it is dead after the FCS.
                txd_d     = ~crc_q[1:0];
                crc_d     = crc_q >> 2;
                fcs_cnt_d = fcs_cnt_q + 4'd1;
                if (fcs_cnt_q == 4'd15) begin
                    state_d   = ST_IFG;
                    ifg_cnt_d = '0;
                    fc_d      = fc_q + 16'd1;
                end
            end
            ST_IFG: begin
                txen_d    = 1'b0;
                txd_d     = 2'b00;
                ifg_cnt_d = ifg_cnt_q + 8'd1;
                if (ifg_cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txen_d  = 1'b0;
                txd_d   = 2'b00;
                stall_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_cnt_q <= '0;
            pay_cnt_q <= '0;
            fcs_cnt_q <= '0;
            ifg_cnt_q <= '0;
            req_cnt_q <= '0;
            crc_q     <= 32'hFFFFFFFF;
            stall_q   <= 1'b1;
            txen_q    <= 1'b0;
            txd_q     <= 2'b00;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            fc_q      <= '0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            fcs_cnt_q <= fcs_cnt_d;
            ifg_cnt_q <= ifg_cnt_d;
            req_cnt_q <= req_cnt_d;
            crc_q     <= crc_d;
            stall_q   <= stall_d;
            txen_q    <= txen_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            fc_q      <= fc_d;
        end
    end

    assign bus.stall        = stall_q;
    assign bus.txen         = txen_q;
    assign bus.txd          = txd_q;
    assign bus.busy         = busy_q;
    assign bus.underrun_err = err_q;
    assign bus.frame_count  = fc_q;
endmodule

// File: tb/tb_rmii_frame_tx.sv
// tb/tb_rmii_frame_tx.sv - directed self-checking bench for rmii_frame_tx
module tb_rmii_frame_tx;
    localparam int PD   = 240;
    localparam int LEAD = 3;
    localparam int IFG  = 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rmii_frame_tx_if bus ();

    rmii_frame_tx #(
        .PAYLOAD_DIBITS(PD),
        .LEAD          (LEAD),
        .IFG_DIBITS    (IFG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Upstream model: a stall-low cycle is answered LEAD cycles later with the next ramp dibit.
    logic [31:0] req_hist  = '0;
    int          up_idx    = 0;
    int          drop_idx  = -1;
    logic        seq_clear = 1'b0;

    always @(negedge clk) begin
        req_hist = {req_hist[30:0], ~bus.stall};
        if (seq_clear) up_idx = 0;
        bus.axiiv = 1'b0;
        bus.axiid = 2'(up_idx);
        if (req_hist[LEAD]) begin
            bus.axiiv = (up_idx != drop_idx);
            up_idx++;
        end
    end

    logic        cap_txen  [0:699];
    logic [1:0]  cap_txd   [0:699];
    logic        cap_stall [0:699];
    logic        cap_busy  [0:699];
    logic        cap_err   [0:699];
    logic [15:0] cap_fc    [0:699];

    // Called just after a negedge: send is high from cycle 0 through cycle hold-1.
    task automatic capture(input int ncyc, input int hold);
        bus.send = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c >= hold) bus.send = 1'b0;
            cap_txen[c]  = bus.txen;
            cap_txd[c]   = bus.txd;
            cap_stall[c] = bus.stall;
            cap_busy[c]  = bus.busy;
            cap_err[c]   = bus.underrun_err;
            cap_fc[c]    = bus.frame_count;
        end
        bus.send = 1'b0;
    endtask

    task automatic restart_ramp();
        seq_clear = 1'b1;
        repeat (2) @(negedge clk);
        seq_clear = 1'b0;
    endtask

    // Byte-wise reference: the 0,1,2,3 dibit ramp packs LSB-first into 0xE4 bytes.
    function automatic logic [31:0] ref_fcs(input int ndibits);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int b = 0; b < ndibits / 4; b++) begin
            c = c ^ 32'h000000E4;
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic check_frame(input int base, input logic [31:0] fcs);
        logic [1:0] exp_txd;
        logic       exp_stall;
        for (int c = 1; c <= 288; c++) begin
            if (c <= 31)           exp_txd = 2'b01;
            else if (c == 32)      exp_txd = 2'b11;
            else if (c <= 32 + PD) exp_txd = 2'(c - 33);
            else                   exp_txd = 2'(fcs >> (2 * (c - 33 - PD)));
            exp_stall = !(c >= 32 - LEAD && c <= 31 - LEAD + PD);
            check($sformatf("txen@%0d", base + c),  32'(cap_txen[base + c]),  32'd1);
            check($sformatf("txd@%0d", base + c),   32'(cap_txd[base + c]),   32'(exp_txd));
            check($sformatf("stall@%0d", base + c), 32'(cap_stall[base + c]), 32'(exp_stall));
        end
        check($sformatf("txen_fall@%0d", base + 289), 32'(cap_txen[base + 289]), 32'd0);
    endtask

    initial begin
        logic [31:0] fcs;
        int          nbad_idle;
        fcs = ref_fcs(PD);

        // T1: reset held with send asserted
        bus.send = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_txen",  32'(bus.txen),         32'd0);
        check("rst_txd",   32'(bus.txd),          32'd0);
        check("rst_stall", 32'(bus.stall),        32'd1);
        check("rst_busy",  32'(bus.busy),         32'd0);
        check("rst_err",   32'(bus.underrun_err), 32'd0);
        check("rst_fc",    32'(bus.frame_count),  32'd0);
        bus.send = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nbad_idle = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.txen || bus.busy || !bus.stall) nbad_idle++;
        end
        check("idle_after_rst", 32'(nbad_idle), 32'd0);

        // T2-T4: send held high across two frames
        restart_ramp();
        capture(680, 400);
        check_frame(0, fcs);
        check("fc@287", 32'(cap_fc[287]), 32'd0);
        check("fc@288", 32'(cap_fc[288]), 32'd1);
        nbad_idle = 0;
        for (int c = 289; c <= 336; c++) if (cap_txen[c] || cap_txd[c] != 2'b00) nbad_idle++;
        check("ifg_idle", 32'(nbad_idle), 32'd0);
        check("busy@335", 32'(cap_busy[335]), 32'd1);
        check("busy@336", 32'(cap_busy[336]), 32'd0);
        check("txen@337", 32'(cap_txen[337]), 32'd1);
        check_frame(336, fcs);
        check("fc@624", 32'(cap_fc[624]), 32'd2);
        check("busy@671", 32'(cap_busy[671]), 32'd1);
        check("busy@672", 32'(cap_busy[672]), 32'd0);
        check("no_third", 32'(cap_txen[680]), 32'd0);

        // T5: dibit 100 missing
        restart_ramp();
        drop_idx = 100;
        capture(200, 1);
        drop_idx = -1;
        check("ur_txen@132", 32'(cap_txen[132]), 32'd1);
        check("ur_txd@132",  32'(cap_txd[132]),  32'd3);
        check("ur_err@132",  32'(cap_err[132]),  32'd0);
        check("ur_txen@133", 32'(cap_txen[133]), 32'd0);
        check("ur_txd@133",  32'(cap_txd[133]),  32'd0);
        check("ur_stall@133", 32'(cap_stall[133]), 32'd1);
        check("ur_err@133",  32'(cap_err[133]),  32'd1);
        check("ur_busy@180", 32'(cap_busy[180]), 32'd1);
        check("ur_busy@181", 32'(cap_busy[181]), 32'd0);
        nbad_idle = 0;
        for (int c = 133; c <= 200; c++) if (cap_txen[c] || !cap_stall[c] || cap_fc[c] != 16'd2) nbad_idle++;
        check("ur_quiet", 32'(nbad_idle), 32'd0);
        check("err_sticky", 32'(bus.underrun_err), 32'd1);

        // T6: async reset in the middle of the payload
        restart_ramp();
        capture(100, 1);
        check("err_cleared", 32'(cap_err[1]), 32'd0);
        check("mid_txen", 32'(cap_txen[100]), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_txen",  32'(bus.txen),        32'd0);
        check("arst_stall", 32'(bus.stall),       32'd1);
        check("arst_busy",  32'(bus.busy),        32'd0);
        check("arst_fc",    32'(bus.frame_count), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        restart_ramp();
        capture(300, 1);
        check_frame(0, fcs);
        check("post_rst_fc", 32'(cap_fc[300]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
